hamming_decode_arbiter: RTL and testbench
=========================================

# hamming_decode_arbiter

Shares one Hamming(7,4) decode datapath between two codeword requesters using round-robin arbitration and valid/ready handshakes. It presents corrected 4-bit data, an error flag and the source channel on a single registered output. It sits between the receive-side codeword sources and the consumer of decoded nibbles. Optional per-channel saturating counters track corrected errors.

## Interface
- CNT_W, 8, width of each per-channel error counter
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in0_valid  input  1  channel 0 codeword valid
- in0_code  input  7  channel 0 codeword H[6:0]
- in0_ready  output  1  channel 0 accepted this cycle when high with in0_valid
- in1_valid, in1_code, in1_ready: same as channel 0, for channel 1
- out_valid  output  1  decoded result valid
- out_data  output  4  corrected data
- out_err  output  1  nonzero syndrome was seen and corrected
- out_ch  output  1  source channel of result
- out_ready  input  1  consumer accepts result
- cnt_clr  input  1  synchronous clear of both error counters (counter build only)
- err_cnt0, err_cnt1  output  CNT_W  per-channel corrected-error count (counter build only)

## Operation
- Syndrome: s2 = H6^H5^H4^H3, s1 = H6^H5^H2^H1, s0 = H6^H4^H2^H0. A nonzero value k in 1..7 flips H[k-1]. Data = {H6,H5,H4,H2} after correction. out_err = (syndrome != 0).
- Output slot: one register holding {data, err, ch}. The slot can load when out_valid is 0 or out_ready is 1.
- Arbitration state: priority pointer `prio` (0/1), reset 0.
  - Only one channel valid: that channel is granted.
  - Both channels valid: channel `prio` is granted.
  - After any accepted transfer from channel i, `prio` becomes ~i. Otherwise `prio` holds.
- in_ready for channel i = grant_i & slot-can-load. in_ready may depend on in_valid. out_valid never depends on out_ready.
- Accept: in_valid & in_ready on the granted channel. On accept the slot loads the decoded result and out_valid is set to 1.
- Drain: out_valid & out_ready with no accept in the same cycle sets out_valid to 0. Simultaneous drain and accept replaces the slot contents, so out_valid stays 1.
- The output is held stable while out_valid & ~out_ready.
- Reset mid-operation: any in-flight result is discarded. No partial state survives.

## Timing
- Reset values: out_valid 0, out_data 0, out_err 0, out_ch 0, prio 0, err_cnt0/1 0. in0_ready/in1_ready are 0 unless the corresponding in_valid is high.
- Latency: 1 cycle from accept edge to out_valid.
- Throughput: 1 codeword per cycle while out_ready is held high.
- Fairness: with both channels continuously valid, grants alternate 0,1,0,1 starting with 0 after reset.
- Backpressure: out_ready low with out_valid high forces both in_ready to 0.

## Configuration
- HAMMING_ARB_CNT_EN defined:
  - cnt_clr, err_cnt0 and err_cnt1 exist.
  - A counter increments on each accept from its channel with a nonzero syndrome.
  - A counter saturates at 2^CNT_W-1.
  - cnt_clr wins over a same-cycle increment.
- HAMMING_ARB_CNT_EN undefined: the ports and counter logic are absent. All other behaviour is identical.

## Structure
- Shared package hamming_pkg holds:
  - code width (7), data width (4) and syndrome width (3) constants;
  - a typedef for the result struct {data, err, ch}.
- Sub-module hamming74_corrector: purely combinational, taking code[6:0] to data[3:0] and err. It is instantiated once, after the grant mux.
- The arbiter pointer, output slot and counters live in the top module.

## Test plan
- Reset, then ch0 sends 7'h55 with out_ready=1 -> next cycle out_valid=1, out_data=4'hB, out_err=0, out_ch=0.
- ch1 sends 7'h75 (H5 flipped) -> out_data=4'hB, out_err=1, out_ch=1. In the counter build err_cnt1 becomes 1.
- Both channels continuously valid with 7'h00 and out_ready=1 -> out_ch sequence 0,1,0,1; out_data=0 each cycle.
- Hold out_ready=0 after one accept -> both in_ready stay 0 and the output stays stable for 5 cycles. Raise out_ready -> the pending request is accepted in the same cycle and the new result appears next cycle.
- Counter build, CNT_W=2: five erroneous ch0 codewords -> err_cnt0 saturates at 3. Pulse cnt_clr together with an erroneous accept -> err_cnt0=0.
- Assert rst while out_valid=1 and prio=1 -> out_valid=0 and prio=0 immediately. With both channels valid after reset, ch0 is granted first.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared widths and the decoded-result bundle for the Hamming(7,4) arbiter.
package hamming_pkg;

  localparam int CODE_W = 7;
  localparam int DATA_W = 4;
  localparam int SYN_W  = 3;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
    logic              ch;
  } result_t;

endpackage

// File: rtl/hamming_decode_arbiter_corrector.sv
// Combinational Hamming(7,4) single-error corrector.
module hamming74_corrector
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [DATA_W-1:0] data,
  output logic              err
);

  logic [SYN_W-1:0]  syn;
  logic [CODE_W-1:0] fixed;

  assign syn[2] = code[6] ^ code[5] ^ code[4] ^ code[3];
  assign syn[1] = code[6] ^ code[5] ^ code[2] ^ code[1];
  assign syn[0] = code[6] ^ code[4] ^ code[2] ^ code[0];

  // Syndrome k names bit position k-1 of the codeword.
  always_comb begin
    fixed = code;
    if (syn != '0)
      fixed[syn - 3'd1] = ~code[syn - 3'd1];
  end

  assign data = {fixed[6], fixed[5], fixed[4], fixed[2]};
  assign err  = (syn != '0);

endmodule

// File: rtl/hamming_decode_arbiter.sv
// Two-channel round-robin front end for one shared Hamming(7,4) decoder.
// Define HAMMING_ARB_CNT_EN to add per-channel saturating error counters.
module hamming_decode_arbiter
  import hamming_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in0_valid,
  input  logic [CODE_W-1:0] in0_code,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [CODE_W-1:0] in1_code,
  output logic              in1_ready,
  input  logic              out_ready,
`ifdef HAMMING_ARB_CNT_EN
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  err_cnt0,
  output logic [CNT_W-1:0]  err_cnt1,
`endif
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic              out_ch
);

  logic              prio;
  logic              gnt0;
  logic              gnt1;
  logic              can_load;
  logic              acc;
  logic [CODE_W-1:0] sel_code;
  logic [DATA_W-1:0] dec_data;
  logic              dec_err;
  result_t           slot;

  assign gnt0 = in0_valid & (~in1_valid | ~prio);
  assign gnt1 = in1_valid & (~in0_valid | prio);

  assign can_load  = ~out_valid | out_ready;
  assign in0_ready = gnt0 & can_load;
  assign in1_ready = gnt1 & can_load;

  assign acc      = (in0_valid & in0_ready) | (in1_valid & in1_ready);
  assign sel_code = gnt1 ? in1_code : in0_code;

  hamming74_corrector u_corr (
    .code (sel_code),
    .data (dec_data),
    .err  (dec_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      slot      <= '0;
      prio      <= 1'b0;
    end else if (acc) begin
      out_valid <= 1'b1;
      slot      <= '{data: dec_data, err: dec_err, ch: gnt1};
      prio      <= ~gnt1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_data = slot.data;
  assign out_err  = slot.err;
  assign out_ch   = slot.ch;

`ifdef HAMMING_ARB_CNT_EN
  logic [CNT_W-1:0] cnt_max;
  logic             inc0;
  logic             inc1;

  assign cnt_max = '1;
  assign inc0    = acc & ~gnt1 & dec_err;
  assign inc1    = acc & gnt1 & dec_err;

  // Clear has priority over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt0 <= '0;
      err_cnt1 <= '0;
    end else if (cnt_clr) begin
      err_cnt0 <= '0;
      err_cnt1 <= '0;
    end else begin
      if (inc0 && err_cnt0 != cnt_max)
        err_cnt0 <= err_cnt0 + 1'b1;
      if (inc1 && err_cnt1 != cnt_max)
        err_cnt1 <= err_cnt1 + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_hamming_decode_arbiter.sv
// Randomised and directed bench for hamming_decode_arbiter.
module tb_hamming_decode_arbiter;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in0_valid = 1'b0;
  logic [6:0]    in0_code = '0;
  logic          in0_ready;
  logic          in1_valid = 1'b0;
  logic [6:0]    in1_code = '0;
  logic          in1_ready;
  logic          out_ready = 1'b0;
  logic          cnt_clr = 1'b0;
  logic          out_valid;
  logic [3:0]    out_data;
  logic          out_err;
  logic          out_ch;
`ifdef HAMMING_ARB_CNT_EN
  logic [CW-1:0] err_cnt0;
  logic [CW-1:0] err_cnt1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  bit       m_valid;
  bit [3:0] m_data;
  bit       m_err;
  bit       m_ch;
  bit       m_prio;
  int       m_cnt0;
  int       m_cnt1;

  hamming_decode_arbiter #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_code  (in0_code),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_code  (in1_code),
    .in1_ready (in1_ready),
    .out_ready (out_ready),
`ifdef HAMMING_ARB_CNT_EN
    .cnt_clr   (cnt_clr),
    .err_cnt0  (err_cnt0),
    .err_cnt1  (err_cnt1),
`endif
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_ch    (out_ch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit [6:0] encode(input bit [3:0] d);
    bit h6, h5, h4, h2;
    {h6, h5, h4, h2} = d;
    return {h6, h5, h4, h6 ^ h5 ^ h4, h2, h6 ^ h5 ^ h2, h6 ^ h4 ^ h2};
  endfunction

  // Nearest-codeword search over all 16 messages.
  task automatic ref_decode(input bit [6:0] c, output bit [3:0] d,
                            output bit e);
    d = 4'h0;
    e = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if ($countones(encode(4'(i)) ^ c) <= 1) begin
        d = 4'(i);
        e = (encode(4'(i)) != c);
      end
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_err = 0; m_ch = 0;
    m_prio = 0; m_cnt0 = 0; m_cnt1 = 0;
  endtask

  task automatic check_outs();
    chk("out_valid", int'(out_valid), int'(m_valid));
    chk("out_data", int'(out_data), int'(m_data));
    chk("out_err", int'(out_err), int'(m_err));
    chk("out_ch", int'(out_ch), int'(m_ch));
`ifdef HAMMING_ARB_CNT_EN
    chk("err_cnt0", int'(err_cnt0), m_cnt0);
    chk("err_cnt1", int'(err_cnt1), m_cnt1);
`endif
  endtask

  // One clock: check outputs, drive, check readies, advance model.
  task automatic step(input bit v0, input bit [6:0] c0, input bit v1,
                      input bit [6:0] c1, input bit ordy, input bit clr);
    bit       win, g0, g1, room, acc;
    bit [3:0] d;
    bit       e;
    check_outs();
    in0_valid = v0; in0_code = c0;
    in1_valid = v1; in1_code = c1;
    out_ready = ordy; cnt_clr = clr;
    #1;
    win  = (v0 && v1) ? m_prio : v1;
    g0   = v0 && win == 0;
    g1   = v1 && win == 1;
    room = !m_valid || ordy;
    chk("in0_ready", int'(in0_ready), int'(g0 && room));
    chk("in1_ready", int'(in1_ready), int'(g1 && room));
    acc = (g0 || g1) && room;
    if (acc) begin
      ref_decode(win ? c1 : c0, d, e);
      m_valid = 1; m_data = d; m_err = e; m_ch = win;
      m_prio = !win;
`ifdef HAMMING_ARB_CNT_EN
      if (e && win == 0 && m_cnt0 < 3) m_cnt0++;
      if (e && win == 1 && m_cnt1 < 3) m_cnt1++;
`endif
    end else if (ordy) begin
      m_valid = 0;
    end
    if (clr) begin
      m_cnt0 = 0;
      m_cnt1 = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic bit [6:0] flip1(input bit [6:0] c);
    bit [6:0] m;
    m = 7'h1 << $urandom_range(6);
    return c ^ m;
  endfunction

  initial begin
    bit [6:0] held;
    model_reset();
    @(negedge clk);
    check_outs();
    chk("rst_in0_ready", int'(in0_ready), 0);
    chk("rst_in1_ready", int'(in1_ready), 0);
    rst = 1'b0;
    @(negedge clk);

    step(1, 7'h55, 0, 7'h00, 1, 0);
    chk("ch0_55_data", int'(out_data), 4'hB);
    chk("ch0_55_err", int'(out_err), 0);
    step(0, 7'h00, 1, 7'h75, 1, 0);
    chk("ch1_75_data", int'(out_data), 4'hB);
    chk("ch1_75_err", int'(out_err), 1);
    chk("ch1_75_ch", int'(out_ch), 1);
    step(0, 7'h00, 0, 7'h00, 1, 0);

    // Fairness: prio is 0 here (last accept was ch1).
    for (int i = 0; i < 4; i++) begin
      step(1, 7'h00, 1, 7'h00, 1, 0);
      chk("fair_ch", int'(out_ch), i % 2);
      chk("fair_data", int'(out_data), 0);
    end
    step(0, 7'h00, 0, 7'h00, 1, 0);

    // Backpressure
    step(1, 7'h2A, 1, 7'h4B, 0, 0);
    held = out_data;
    for (int i = 0; i < 5; i++) step(1, 7'h2A, 1, 7'h4B, 0, 0);
    chk("bp_hold", int'(out_data), int'(held));
    step(1, 7'h2A, 1, 7'h4B, 1, 0);
    step(0, 7'h00, 0, 7'h00, 1, 0);

`ifdef HAMMING_ARB_CNT_EN
    for (int i = 0; i < 5; i++)
      step(1, flip1(encode(4'($urandom))), 0, 7'h00, 1, 0);
    check_outs();
    chk("cnt0_sat", int'(err_cnt0), 3);
    step(1, flip1(encode(4'h9)), 0, 7'h00, 1, 1);
    chk("cnt0_clr", int'(err_cnt0), 0);
`endif

    // Random traffic: mix of clean and single-error codewords
    for (int i = 0; i < 400; i++) begin
      bit [6:0] a, b;
      a = encode(4'($urandom));
      b = encode(4'($urandom));
      if ($urandom_range(1)) a = flip1(a);
      if ($urandom_range(1)) b = flip1(b);
      step(1'($urandom), a, 1'($urandom), b,
           $urandom_range(3) != 0, $urandom_range(15) == 0);
    end
    step(0, 7'h00, 0, 7'h00, 1, 0);

    // Mid-operation reset with prio=1 and a result stalled
    step(1, 7'h33, 0, 7'h00, 0, 0);
    check_outs();
    chk("pre_rst_valid", int'(out_valid), 1);
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    @(negedge clk);
    rst = 1'b0;
    step(1, 7'h0F, 1, 7'h70, 1, 0);
    chk("post_rst_ch", int'(out_ch), 0);
    check_outs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
